ras_checker: RTL and testbench
==============================

Name: ras_checker

Overview:
- Resolution-side counterpart of the fetch-stage return address stack (RAS) predictor.
- Each taken RAS prediction (predicted target) is queued in order. When execute resolves the corresponding return, the actual target is compared with the oldest queued prediction.
- Outputs: mispredict indication plus corrected target. After repeated consecutive misses, a one-cycle invalidate pulse for the RAS (drives its s_invalidate_i).

Parameters:
- DEPTH, 4, outstanding-prediction queue entries; power of two, >=2.
- MISS_LIMIT, 3, consecutive mispredicts that trigger RAS invalidate; 1..15.

Ports:
- s_clk_i  in  1  clock
- s_resetn_i  in  1  reset, asynchronous, active-low
- s_flush_i  in  1  pipeline flush; discards outstanding predictions
- s_pred_valid_i  in  1  RAS prediction taken this cycle (OR of RAS s_poped_o bits)
- s_pred_addr_i  in  31  predicted target, halfword address
- s_res_valid_i  in  1  execute resolves one predicted return this cycle
- s_res_addr_i  in  31  actual target, halfword address
- s_full_o  out  1  queue holds DEPTH entries
- s_mispredict_o  out  1  registered compare result: mismatch
- s_correct_addr_o  out  31  registered s_res_addr_i accompanying s_mispredict_o
- s_invalidate_o  out  1  one-cycle pulse to invalidate RAS
- s_desync_o  out  1  checker is in DESYNC state

Behaviour:
- Reset: queue empty, state TRACK, miss counter 0, all outputs 0.
- Queue is an in-order FIFO of 31-bit predictions.
  - Push on s_pred_valid_i.
  - Pop on s_res_valid_i.
  - Simultaneous push+pop legal at any fill level. Count unchanged; at full, no overflow.
- Compare latency is 1 cycle.
  - In cycle N, with TRACK, res_valid and queue non-empty: in cycle N+1, s_mispredict_o = (head != s_res_addr_i) and s_correct_addr_o = s_res_addr_i.
  - s_mispredict_o is 0 in every other cycle. s_correct_addr_o holds its last value.
- Miss counter, 4 bits:
  - Increments on each mismatch.
  - Clears on a match.
  - On the mismatch that brings it to MISS_LIMIT: counter clears; in cycle N+1, s_invalidate_o=1 together with s_mispredict_o; queue is emptied at the same edge.
- FSM states: TRACK, DESYNC, INVAL.
  - TRACK -> DESYNC:
    - push while full without a simultaneous pop (prediction dropped), or
    - res_valid while empty, including a same-cycle push into an empty queue; no bypass.
  - DESYNC:
    - no compares, no counter updates, pushes and pops ignored, queue emptied on entry.
    - s_desync_o=1.
    - Exits to TRACK only on s_flush_i.
  - TRACK -> INVAL on MISS_LIMIT mismatch.
    - INVAL lasts exactly one cycle (the cycle with s_invalidate_o=1) and returns to TRACK.
    - Push/res during INVAL are ignored.
- Flush:
  - Dominates push/res in the same cycle.
  - Next cycle: queue empty, state TRACK, s_mispredict_o=0, s_invalidate_o=0.
  - Miss counter preserved.
  - If the flush cycle is itself an INVAL cycle, the pulse already present completes; no extension.
- Pointers: log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty derived from MSB difference.
- Address compare is full 31-bit equality. No arithmetic on addresses.

Decomposition:
- p_hardisc gains typedef ras_chk_state_t {TRACK, DESYNC, INVAL} and constant RAS_ADDR_W = 31.
- Sub-module ras_pred_fifo: DEPTH x RAS_ADDR_W FIFO with push, pop, clear, head, full and empty outputs. Storage via seu_regs so fault-injection labels (group 5) match the RAS.
- FSM, compare register and miss counter stay in ras_checker.

Test Plan:
- Push 0x0000_1000, 0x0000_2000; resolve 0x1000 then 0x2000 -> s_mispredict_o 0,0 at N+1; queue empty; counter 0.
- Push 0x100; resolve 0x104 -> N+1: s_mispredict_o=1, s_correct_addr_o=0x104; counter=1. Then push 0x200, resolve 0x200 -> counter back to 0.
- MISS_LIMIT=3: three pushes, three mismatching resolves -> third response has s_mispredict_o=1 and s_invalidate_o=1 for exactly 1 cycle; queue empty; counter 0.
- Fill DEPTH=4, push a 5th without pop -> s_desync_o=1, later resolves give no mispredict. Flush -> s_desync_o=0, empty, TRACK.
- Full queue with simultaneous push 0x500 + resolve matching head -> no desync; s_full_o stays 1; 0x500 is tail.
- Flush with push and res in the same cycle -> neither takes effect; next cycle empty, mispredict 0. Assert s_resetn_i mid-sequence -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/ras_checker_pkg.sv
// ---------------------------------------------------------------------------
// ras_checker_pkg
// Shared types and constants for the RAS resolution checker.
//   RAS_ADDR_W      : width of a halfword return address
//   ras_addr_t      : halfword return address
//   ras_chk_state_t : checker FSM states (TRACK / DESYNC / INVAL)
// ---------------------------------------------------------------------------
package ras_checker_pkg;

  localparam int RAS_ADDR_W = 31;

  typedef logic [RAS_ADDR_W-1:0] ras_addr_t;

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    DESYNC = 2'd1,
    INVAL  = 2'd2
  } ras_chk_state_t;

endpackage

// File: rtl/ras_checker_pred_fifo.sv
// ---------------------------------------------------------------------------
// ras_pred_fifo
// In-order queue of outstanding RAS predictions.
// Ports:
//   s_clk_i, s_resetn_i : clock, asynchronous active-low reset (pointers only)
//   s_push_i, s_data_i  : enqueue a prediction
//   s_pop_i             : dequeue the head
//   s_clear_i           : empty the queue; dominates push/pop
//   s_head_o            : oldest entry (valid when s_empty_o = 0)
//   s_full_o, s_empty_o : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
// ---------------------------------------------------------------------------
module ras_pred_fifo
  import ras_checker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      s_clk_i,
  input  logic      s_resetn_i,
  input  logic      s_push_i,
  input  ras_addr_t s_data_i,
  input  logic      s_pop_i,
  input  logic      s_clear_i,
  output ras_addr_t s_head_o,
  output logic      s_full_o,
  output logic      s_empty_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;
  ras_addr_t     entries [DEPTH];

  assign s_empty_o = (wr_ptr_q == rd_ptr_q);
  assign s_full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);

  // A push into a full queue is accepted only when the head leaves at the
  // same edge; the slot being written is then the one being vacated.
  assign do_pop  = s_pop_i && !s_empty_o;
  assign do_push = s_push_i && (!s_full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (s_clear_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // One independent register per entry; contents need no reset because the
  // pointers define which entries are meaningful.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    ras_addr_t entry_q;
    logic      wr_en;

    assign wr_en = do_push && !s_clear_i && (wr_ptr_q[IW-1:0] == IW'(gi));

    always_ff @(posedge s_clk_i) begin
      if (wr_en) entry_q <= s_data_i;
    end

    assign entries[gi] = entry_q;
  end

  assign s_head_o = entries[rd_ptr_q[IW-1:0]];

endmodule

// File: rtl/ras_checker.sv
// ---------------------------------------------------------------------------
// ras_checker
// Resolution-side checker for the fetch-stage return address stack.
// Taken RAS predictions are queued in order; each resolved return is
// compared against the oldest prediction one cycle later.
// Ports:
//   s_clk_i, s_resetn_i : clock, asynchronous active-low reset
//   s_flush_i           : pipeline flush, discards outstanding predictions
//   s_pred_valid_i/addr : RAS prediction taken this cycle
//   s_res_valid_i/addr  : execute resolves one predicted return
//   s_full_o            : prediction queue holds DEPTH entries
//   s_mispredict_o      : registered mismatch of the last compare
//   s_correct_addr_o    : resolved target accompanying s_mispredict_o
//   s_invalidate_o      : one-cycle RAS invalidate after MISS_LIMIT misses
//   s_desync_o          : checker lost track of the RAS, waiting for flush
// ---------------------------------------------------------------------------
module ras_checker
  import ras_checker_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MISS_LIMIT = 3
) (
  input  logic      s_clk_i,
  input  logic      s_resetn_i,
  input  logic      s_flush_i,
  input  logic      s_pred_valid_i,
  input  ras_addr_t s_pred_addr_i,
  input  logic      s_res_valid_i,
  input  ras_addr_t s_res_addr_i,
  output logic      s_full_o,
  output logic      s_mispredict_o,
  output ras_addr_t s_correct_addr_o,
  output logic      s_invalidate_o,
  output logic      s_desync_o
);

  localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);

  ras_chk_state_t state_q, state_d;
  logic [3:0]     miss_cnt_q, miss_cnt_d;
  logic           mispredict_q, mispredict_d;
  ras_addr_t      correct_addr_q, correct_addr_d;

  logic      fifo_push;
  logic      fifo_pop;
  logic      fifo_clear;
  ras_addr_t fifo_head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      mismatch;

  ras_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .s_clk_i    (s_clk_i),
    .s_resetn_i (s_resetn_i),
    .s_push_i   (fifo_push),
    .s_data_i   (s_pred_addr_i),
    .s_pop_i    (fifo_pop),
    .s_clear_i  (fifo_clear),
    .s_head_o   (fifo_head),
    .s_full_o   (fifo_full),
    .s_empty_o  (fifo_empty)
  );

  assign mismatch = (fifo_head != s_res_addr_i);

  // State and datapath registers
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q        <= TRACK;
      miss_cnt_q     <= '0;
      mispredict_q   <= 1'b0;
      correct_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      miss_cnt_q     <= miss_cnt_d;
      mispredict_q   <= mispredict_d;
      correct_addr_q <= correct_addr_d;
    end
  end

  // Next-state, queue control, compare and miss counter
  always_comb begin
    state_d        = state_q;
    miss_cnt_d     = miss_cnt_q;
    mispredict_d   = 1'b0;
    correct_addr_d = correct_addr_q;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_clear     = 1'b0;

    if (s_flush_i) begin
      // Flush wins over everything; the miss counter deliberately survives.
      state_d    = TRACK;
      fifo_clear = 1'b1;
    end else begin
      unique case (state_q)
        TRACK: begin
          if (s_res_valid_i && fifo_empty) begin
            // Resolution with nothing to compare; a same-cycle push does not
            // bypass, so the pairing is lost.
            state_d    = DESYNC;
            fifo_clear = 1'b1;
          end else if (s_pred_valid_i && fifo_full && !s_res_valid_i) begin
            // Prediction would be dropped.
            state_d    = DESYNC;
            fifo_clear = 1'b1;
          end else begin
            fifo_push = s_pred_valid_i;
            fifo_pop  = s_res_valid_i;
            if (s_res_valid_i) begin
              mispredict_d   = mismatch;
              correct_addr_d = s_res_addr_i;
              if (!mismatch) begin
                miss_cnt_d = '0;
              end else if (miss_cnt_q == MISS_LAST) begin
                miss_cnt_d = '0;
                state_d    = INVAL;
                fifo_clear = 1'b1;
              end else begin
                miss_cnt_d = miss_cnt_q + 4'd1;
              end
            end
          end
        end
        INVAL:   state_d = TRACK;
        DESYNC:  state_d = DESYNC;
        default: state_d = TRACK;
      endcase
    end
  end

  // Outputs
  always_comb begin
    s_desync_o     = (state_q == DESYNC);
    s_invalidate_o = (state_q == INVAL);
  end

  assign s_full_o         = fifo_full;
  assign s_mispredict_o   = mispredict_q;
  assign s_correct_addr_o = correct_addr_q;

endmodule

// File: tb/tb_ras_checker.sv
module tb_ras_checker;

  localparam int DEPTH      = 4;
  localparam int MISS_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        pv = 1'b0;
  logic [30:0] pa = '0;
  logic        rv = 1'b0;
  logic [30:0] ra = '0;
  logic        full_o, mis_o, inv_o, des_o;
  logic [30:0] ca_o;

  int checks = 0;
  int errors = 0;

  ras_checker #(
    .DEPTH      (DEPTH),
    .MISS_LIMIT (MISS_LIMIT)
  ) dut (
    .s_clk_i          (clk),
    .s_resetn_i       (rst_n),
    .s_flush_i        (flush),
    .s_pred_valid_i   (pv),
    .s_pred_addr_i    (pa),
    .s_res_valid_i    (rv),
    .s_res_addr_i     (ra),
    .s_full_o         (full_o),
    .s_mispredict_o   (mis_o),
    .s_correct_addr_o (ca_o),
    .s_invalidate_o   (inv_o),
    .s_desync_o       (des_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic m, input logic i, input logic d,
                         input logic f, input logic [30:0] c);
    chk({tag, ".mispredict"}, {31'd0, mis_o}, {31'd0, m});
    chk({tag, ".invalidate"}, {31'd0, inv_o}, {31'd0, i});
    chk({tag, ".desync"},     {31'd0, des_o}, {31'd0, d});
    chk({tag, ".full"},       {31'd0, full_o}, {31'd0, f});
    chk({tag, ".correct_addr"}, {1'b0, ca_o}, {1'b0, c});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fl;
    logic        pv;
    logic [30:0] pa;
    logic        rv;
    logic [30:0] ra;
    logic        e_mis;
    logic        e_inv;
    logic        e_des;
    logic        e_full;
    logic [30:0] e_ca;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl_, input logic pv_, input logic [30:0] pa_,
                     input logic rv_, input logic [30:0] ra_,
                     input logic m, input logic i, input logic d, input logic f,
                     input logic [30:0] c);
    vec_t v;
    v.fl = fl_; v.pv = pv_; v.pa = pa_; v.rv = rv_; v.ra = ra_;
    v.e_mis = m; v.e_inv = i; v.e_des = d; v.e_full = f; v.e_ca = c;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Model state: 0 tracking, 1 lost sync, 2 invalidate cycle
  logic [30:0] mq[$];
  int          mst;
  int          mmiss;
  logic        mmis;
  logic [30:0] mca;

  task automatic model_reset();
    mq.delete();
    mst = 0; mmiss = 0; mmis = 1'b0; mca = '0;
  endtask

  task automatic model_step();
    logic [30:0] h;
    bit          dropped;
    mmis = 1'b0;
    if (flush) begin
      mq.delete();
      mst = 0;
    end else if (mst == 2) begin
      mst = 0;
    end else if (mst == 0) begin
      if (rv && mq.size() == 0) begin
        mst = 1; mq.delete();
      end else if (pv && mq.size() == DEPTH && !rv) begin
        mst = 1; mq.delete();
      end else begin
        dropped = 1'b0;
        if (rv) begin
          h = mq.pop_front();
          mmis = (h != ra);
          mca = ra;
          if (mmis) begin
            mmiss++;
            if (mmiss == MISS_LIMIT) begin
              mmiss = 0; mst = 2; mq.delete(); dropped = 1'b1;
            end
          end else begin
            mmiss = 0;
          end
        end
        if (pv && !dropped) mq.push_back(pa);
      end
    end
  endtask

  function automatic logic [30:0] rnd_addr();
    case ($urandom_range(0, 4))
      0: return 31'h0000_1000;
      1: return 31'h0000_1002;
      2: return 31'h7FFF_FFFF;
      3: return 31'h4000_1000;
      default: return 31'($urandom_range(0, 1));
    endcase
  endfunction

  initial begin
    // Fill table: {flush, push, paddr, res, raddr} -> {mis, inv, desync, full, corr}
    add(0,1,'h1000,0,0,       0,0,0,0,0);
    add(0,1,'h2000,0,0,       0,0,0,0,0);
    add(0,0,0,1,'h1000,       0,0,0,0,'h1000);
    add(0,0,0,1,'h2000,       0,0,0,0,'h2000);
    add(0,0,0,0,0,            0,0,0,0,'h2000);
    add(0,1,'h100,0,0,        0,0,0,0,'h2000);
    add(0,0,0,1,'h104,        1,0,0,0,'h104);
    add(0,1,'h200,0,0,        0,0,0,0,'h104);
    add(0,0,0,1,'h200,        0,0,0,0,'h200);
    add(0,1,'hA,0,0,          0,0,0,0,'h200);
    add(0,1,'hB,0,0,          0,0,0,0,'h200);
    add(0,1,'hC,0,0,          0,0,0,0,'h200);
    add(0,1,'hD,0,0,          0,0,0,1,'h200);
    add(0,0,0,1,'h1,          1,0,0,0,'h1);
    add(0,0,0,1,'h2,          1,0,0,0,'h2);
    add(0,0,0,1,'h3,          1,1,0,0,'h3);
    add(0,1,'h77,1,'hD,       0,0,0,0,'h3);
    add(0,0,0,1,'hD,          0,0,1,0,'h3);
    add(1,0,0,0,0,            0,0,0,0,'h3);
    add(0,1,'h11,0,0,         0,0,0,0,'h3);
    add(0,1,'h12,0,0,         0,0,0,0,'h3);
    add(0,1,'h13,0,0,         0,0,0,0,'h3);
    add(0,1,'h14,0,0,         0,0,0,1,'h3);
    add(0,1,'h15,0,0,         0,0,1,0,'h3);
    add(0,0,0,1,'h99,         0,0,1,0,'h3);
    add(0,1,'h16,1,'h11,      0,0,1,0,'h3);
    add(1,0,0,0,0,            0,0,0,0,'h3);
    add(0,0,0,0,0,            0,0,0,0,'h3);
    add(0,1,'h10,0,0,         0,0,0,0,'h3);
    add(0,1,'h20,0,0,         0,0,0,0,'h3);
    add(0,1,'h30,0,0,         0,0,0,0,'h3);
    add(0,1,'h40,0,0,         0,0,0,1,'h3);
    add(0,1,'h500,1,'h10,     0,0,0,1,'h10);
    add(0,0,0,1,'h20,         0,0,0,0,'h20);
    add(0,0,0,1,'h30,         0,0,0,0,'h30);
    add(0,0,0,1,'h40,         0,0,0,0,'h40);
    add(0,0,0,1,'h500,        0,0,0,0,'h500);
    add(0,1,'h60,0,0,         0,0,0,0,'h500);
    add(1,1,'h70,1,'h61,      0,0,0,0,'h500);
    add(0,0,0,1,'h70,         0,0,1,0,'h500);
    add(1,0,0,0,0,            0,0,0,0,'h500);
    add(0,1,'h1,0,0,          0,0,0,0,'h500);
    add(0,0,0,1,'h2,          1,0,0,0,'h2);
    add(1,0,0,0,0,            0,0,0,0,'h2);
    add(0,1,'h1,0,0,          0,0,0,0,'h2);
    add(0,0,0,1,'h3,          1,0,0,0,'h3);
    add(0,1,'h1,0,0,          0,0,0,0,'h3);
    add(0,0,0,1,'h4,          1,1,0,0,'h4);
    add(1,0,0,0,0,            0,0,0,0,'h4);
    add(0,0,0,0,0,            0,0,0,0,'h4);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      flush = vecs[i].fl; pv = vecs[i].pv; pa = vecs[i].pa;
      rv = vecs[i].rv; ra = vecs[i].ra;
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), vecs[i].e_mis, vecs[i].e_inv, vecs[i].e_des,
              vecs[i].e_full, vecs[i].e_ca);
      $display("row %0d fl=%0b push=%0b/%0h res=%0b/%0h -> mis=%0b inv=%0b des=%0b full=%0b ca=%0h",
               i, vecs[i].fl, vecs[i].pv, vecs[i].pa, vecs[i].rv, vecs[i].ra,
               mis_o, inv_o, des_o, full_o, ca_o);
    end

    // Asynchronous reset mid-cycle with live outputs
    flush = 0; rv = 0; pv = 1;
    for (int i = 0; i < DEPTH; i++) begin
      pa = 31'(i + 'h300);
      @(posedge clk);
      #1;
    end
    pa = 'h399; rv = 1; ra = 'h123;
    @(posedge clk);
    #1;
    pv = 0; rv = 0;
    chk_all("pre_reset", 1, 0, 0, 1, 'h123);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    $display("async reset applied mid-cycle -> mis=%0b full=%0b ca=%0h", mis_o, full_o, ca_o);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Randomized run against the reference model
    for (int n = 0; n < 3000; n++) begin
      flush = ($urandom_range(0, 15) == 0);
      pv    = $urandom_range(0, 1) == 1;
      pa    = rnd_addr();
      rv    = ($urandom_range(0, 2) == 0);
      ra    = rnd_addr();
      @(posedge clk);
      model_step();
      #1;
      chk_all($sformatf("rand%0d", n), mmis, (mst == 2), (mst == 1),
              (mq.size() == DEPTH), mca);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
